dmem_arb: RTL
=============

DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 Parameter MAX_BURST, default 4: consecutive accepted transfers one master may take on a channel while the other requests (round-robin mode only); range 1..15.
REQ-002 clk  input  1  clock, all state on rising edge.
REQ-003 resetb  input  1  reset; asynchronous, active-low.
REQ-004 m_wready  input  2  per-master write request; bit i = master i, m0 = core, m1 = secondary (DMA/debug).
REQ-005 m_wvalid  output  2  per-master write accept.
REQ-006 m_waddr  input  64  write addresses, [31:0] = m0, [63:32] = m1.
REQ-007 m_wdata  input  64  write data, same packing.
REQ-008 m_wstrb  input  8  byte strobes, [3:0] = m0, [7:4] = m1.
REQ-009 m_rready  input  2  per-master read request.
REQ-010 m_rvalid  output  2  per-master read accept.
REQ-011 m_raddr  input  64  read addresses, same packing.
REQ-012 m_rresp  output  2  per-master read-data strobe.
REQ-013 m_rdata  output  32  read data, broadcast to both masters.
REQ-014 s_wready / s_wvalid / s_waddr / s_wdata / s_wstrb  out/in/out/out/out  1/1/32/32/4  shared data-RAM write port.
REQ-015 s_rready / s_rvalid / s_raddr / s_rresp / s_rdata  out/in/out/in/in  1/1/32/1/32  shared data-RAM read port; slave returns s_rresp/s_rdata exactly one cycle after accept.

Function
REQ-016 Write and read channels each have an independent arbiter (grant, lock, pointer, burst counter); no interaction between channels.
REQ-017 Per-channel states: IDLE (no lock) and LOCK (grant held for a master whose request the slave has not accepted).
REQ-018 IDLE: grant computed combinationally this cycle from requests; zero added latency; s_*ready = OR of granted request, slave address/data/strobe muxed from granted master.
REQ-019 Accept: m_*valid[i] = s_*valid AND grant[i]; the ungranted bit is 0.
REQ-020 IDLE -> LOCK when granted request is high and s_*valid low; LOCK -> IDLE on accept; grant cannot change while in LOCK.
REQ-021 LOCK with locked master's request dropped (protocol violation): return to IDLE next cycle, no accept issued, pointer and counter unchanged.
REQ-022 Only one master requesting: it is granted regardless of pointer or counter.
REQ-023 Both requesting in IDLE: master indicated by pointer wins; pointer = 0 after reset.
REQ-024 Burst counter (4 bits) increments on each accept by the same master, resets to 1 on accept by the other master; when it reaches MAX_BURST while the other master requests, pointer moves to the other master and counter clears.
REQ-025 Pointer also moves to the other master on any accept when the other master was requesting in that cycle and MAX_BURST = 1.
REQ-026 Read return: on read accept register rpend=1 and rsel=granted index; next cycle m_rresp[rsel] = s_rresp AND rpend, other bit 0; m_rdata = s_rdata always.
REQ-027 Back-to-back reads (accept every cycle) supported; rsel/rpend update every accept, returns stay ordered.

Reset
REQ-028 resetb low: both channels IDLE, pointers 0, counters 0, rpend 0, rsel 0; in-flight read response discarded (m_rresp = 0 next cycle even if s_rresp high).
REQ-029 Outputs are combinational from state and inputs; with all requests low m_wvalid, m_rvalid, m_rresp = 0 and s_wready, s_rready = 0.

Configuration
REQ-030 Macro DMEM_ARB_RR_EN defined: round-robin with burst limit per REQ-023..025.
REQ-031 Macro undefined: fixed priority, m0 wins every contested IDLE cycle; pointer and counter logic removed, MAX_BURST ignored; REQ-017..021, 026..029 unchanged.

Verification
REQ-032 Only m0 writes addr 0x0000_0100 data 0xDEAD_BEEF strb 0xF, s_wvalid=1 -> same-cycle m_wvalid=2'b01, slave sees exact addr/data/strb.
REQ-033 Both read continuously, s_rvalid=1, MAX_BURST=4, RR -> grant sequence m0,m0,m0,m0,m1,m1,m1,m1,m0...; m_rresp bit matches grantee one cycle later.
REQ-034 m1 write, s_wvalid low for 3 cycles while m0 raises request -> grant stays m1 (LOCK), m1 accepted on 4th cycle, m0 granted next.
REQ-035 Read accepted for m1, resetb pulsed low before return -> m_rresp=2'b00 during return cycle; after release m0 wins first contested cycle.
REQ-036 Without DMEM_ARB_RR_EN, both write continuously for 10 cycles -> m_wvalid=2'b01 all 10 cycles, m1 never accepted.

Source files
------------

// File: rtl/dmem_arb.sv
// dmem_arb: two-master arbiter in front of a single-ported data RAM.
// Write and read channels each run their own arbiter (dmem_arb_ch). A
// granted request is presented to the slave in the same cycle. A request the
// slave does not accept locks the grant until it is accepted or withdrawn.
// Read responses come back one cycle after accept and are steered to the
// master that was accepted.
// Build option: define DMEM_ARB_RR_EN for round-robin with a per-master burst
// limit (MAX_BURST). Without it, master 0 wins every contested cycle.

// Per-channel arbiter.
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no grant held; grant is computed from this cycle's requests
// LOCK    | grant held for master lock_q until the slave accepts it
module dmem_arb_ch #(
   parameter int MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       resetb,
   input  logic [1:0] req_i,
   input  logic       s_valid_i,
   output logic       sel_o,
   output logic       s_ready_o,
   output logic [1:0] valid_o
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_LOCK = 1'b1;

   logic [0:0] state_q, state_d;
   logic       lock_q, lock_d;
   logic       sel;
   logic       active;
   logic       accept;
   logic       contest_pick;

`ifdef DMEM_ARB_RR_EN
   localparam logic [3:0] MAX_B = 4'(MAX_BURST);

   logic       ptr_q, ptr_d;
   logic       last_q, last_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] cnt_run;

   assign contest_pick = ptr_q;
`else
   localparam int unused_max_burst = MAX_BURST;

   assign contest_pick = 1'b0;
`endif

   // Pick the master to present: held grant in LOCK, else from requests.
   always_comb begin
      sel = 1'b0;
      if (state_q == ST_LOCK) begin
         sel = lock_q;
      end else if (req_i == 2'b10) begin
         sel = 1'b1;
      end else if (req_i == 2'b11) begin
         sel = contest_pick;
      end
   end

   // A locked master that drops its request gets no accept this cycle.
   assign active    = req_i[sel];
   assign accept    = active & s_valid_i;
   assign s_ready_o = active;
   assign sel_o     = sel;
   assign valid_o   = {accept & sel, accept & ~sel};

   // Lock the grant while the slave stalls; release on accept or withdrawal.
   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      if (state_q == ST_IDLE) begin
         if (active && !s_valid_i) begin
            state_d = ST_LOCK;
            lock_d  = sel;
         end
      end else if (!active || s_valid_i) begin
         state_d = ST_IDLE;
      end
   end

   // Grant state registers.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q <= ST_IDLE;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
      end
   end

`ifdef DMEM_ARB_RR_EN
   // Burst accounting: hand the pointer over once a master has used its
   // burst while the other one is waiting. The run count saturates so an
   // uncontested master can stream indefinitely.
   always_comb begin
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      cnt_run = cnt_q;
      if (accept) begin
         if (sel == last_q) begin
            cnt_run = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
         end else begin
            cnt_run = 4'd1;
         end
         last_d = sel;
         if (req_i[!sel] && (cnt_run >= MAX_B)) begin
            ptr_d = !sel;
            cnt_d = 4'd0;
         end else begin
            cnt_d = cnt_run;
         end
      end
   end

   // Round-robin registers.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         ptr_q  <= 1'b0;
         cnt_q  <= 4'd0;
         last_q <= 1'b0;
      end else begin
         ptr_q  <= ptr_d;
         cnt_q  <= cnt_d;
         last_q <= last_d;
      end
   end
`endif

endmodule

module dmem_arb #(
   parameter int MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic [1:0]  m_wready_i,
   output logic [1:0]  m_wvalid_o,
   input  logic [63:0] m_waddr_i,
   input  logic [63:0] m_wdata_i,
   input  logic [7:0]  m_wstrb_i,
   input  logic [1:0]  m_rready_i,
   output logic [1:0]  m_rvalid_o,
   input  logic [63:0] m_raddr_i,
   output logic [1:0]  m_rresp_o,
   output logic [31:0] m_rdata_o,
   output logic        s_wready_o,
   input  logic        s_wvalid_i,
   output logic [31:0] s_waddr_o,
   output logic [31:0] s_wdata_o,
   output logic [3:0]  s_wstrb_o,
   output logic        s_rready_o,
   input  logic        s_rvalid_i,
   output logic [31:0] s_raddr_o,
   input  logic        s_rresp_i,
   input  logic [31:0] s_rdata_i
);

   logic w_sel;
   logic r_sel;
   logic rpend_q, rpend_d;
   logic rsel_q, rsel_d;

   dmem_arb_ch #(.MAX_BURST(MAX_BURST)) u_wch (
      .clk       (clk),
      .resetb    (resetb),
      .req_i     (m_wready_i),
      .s_valid_i (s_wvalid_i),
      .sel_o     (w_sel),
      .s_ready_o (s_wready_o),
      .valid_o   (m_wvalid_o)
   );

   dmem_arb_ch #(.MAX_BURST(MAX_BURST)) u_rch (
      .clk       (clk),
      .resetb    (resetb),
      .req_i     (m_rready_i),
      .s_valid_i (s_rvalid_i),
      .sel_o     (r_sel),
      .s_ready_o (s_rready_o),
      .valid_o   (m_rvalid_o)
   );

   assign s_waddr_o = w_sel ? m_waddr_i[63:32] : m_waddr_i[31:0];
   assign s_wdata_o = w_sel ? m_wdata_i[63:32] : m_wdata_i[31:0];
   assign s_wstrb_o = w_sel ? m_wstrb_i[7:4]   : m_wstrb_i[3:0];
   assign s_raddr_o = r_sel ? m_raddr_i[63:32] : m_raddr_i[31:0];

   // Remember who was accepted so next cycle's response goes to them.
   always_comb begin
      rpend_d = |m_rvalid_o;
      rsel_d  = (|m_rvalid_o) ? r_sel : rsel_q;
   end

   // Read return tracking; reset drops any response still in flight.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         rpend_q <= 1'b0;
         rsel_q  <= 1'b0;
      end else begin
         rpend_q <= rpend_d;
         rsel_q  <= rsel_d;
      end
   end

   assign m_rresp_o = {rpend_q & rsel_q & s_rresp_i, rpend_q & ~rsel_q & s_rresp_i};
   assign m_rdata_o = s_rdata_i;

endmodule
